panda_regfile: RTL and testbench

//  - Integer register file of the Panda RISC-V core: Depth x Width-bit registers.
//  - Two combinational read ports (rs1, rs2) and one synchronous write port (rd).
//  - Register 0 is hard-wired to zero.
//  - Sits between decode (operand fetch) and writeback.

---
 rtl/panda_pkg.sv | 11 +
 rtl/panda_regfile_rdport.sv | 24 ++
 rtl/panda_regfile.sv | 62 ++++++
 tb/tb_panda_regfile.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/panda_pkg.sv
// Shared constants and types for the Panda core.
// Register-file addressing and data widths live here.
package panda_pkg;

  localparam int RegAddrW = 5;
  localparam int XLEN     = 32;

  typedef logic [RegAddrW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]     reg_data_t;

endpackage

// File: rtl/panda_regfile_rdport.sv
// Combinational register-file read mux.
// Address 0 always returns zero; x0 has no storage.
module panda_regfile_rdport
  import panda_pkg::*;
#(
  parameter int Width = XLEN,
  parameter int Depth = 2 ** RegAddrW,
  parameter int AddrW = $clog2(Depth)
) (
  input  logic [AddrW-1:0]             addr_i,
  input  logic [Depth-1:1][Width-1:0] regs_i,
  output logic [Width-1:0]             data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 1; i < Depth; i++) begin
      if (addr_i == AddrW'(i)) begin
        data_o = regs_i[i];
      end
    end
  end

endmodule

// File: rtl/panda_regfile.sv
// Panda integer register file: 2 combinational reads, 1 sync write.
// x0 is not stored; reads never see a same-cycle write.
module panda_regfile
  import panda_pkg::*;
#(
  parameter int Width = XLEN,
  parameter int Depth = 2 ** RegAddrW
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [$clog2(Depth)-1:0] rs1_addr_i,
  output logic [Width-1:0]         rs1_data_o,
  input  logic [$clog2(Depth)-1:0] rs2_addr_i,
  output logic [Width-1:0]         rs2_data_o,
  input  logic [$clog2(Depth)-1:0] rd_addr_i,
  input  logic [Width-1:0]         rd_data_i,
  input  logic                     rd_we_i
);

  localparam int AddrW = $clog2(Depth);

  logic [Depth-1:1][Width-1:0] regs_q;
  logic [Depth-1:1][Width-1:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < Depth; i++) begin
      if (rd_we_i && rd_addr_i == AddrW'(i)) begin
        regs_d[i] = rd_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  panda_regfile_rdport #(
    .Width(Width),
    .Depth(Depth),
    .AddrW(AddrW)
  ) u_rs1 (
    .addr_i(rs1_addr_i),
    .regs_i(regs_q),
    .data_o(rs1_data_o)
  );

  panda_regfile_rdport #(
    .Width(Width),
    .Depth(Depth),
    .AddrW(AddrW)
  ) u_rs2 (
    .addr_i(rs2_addr_i),
    .regs_i(regs_q),
    .data_o(rs2_data_o)
  );

endmodule

// File: tb/tb_panda_regfile.sv
// Randomized scoreboard bench for panda_regfile.
// Reference model is a plain array updated on each accepted write.
module tb_panda_regfile;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst_i = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data = '0;
  logic        rd_we = 1'b0;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  always #5 clk = clk_en ? ~clk : 1'b0;

  panda_regfile dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .rs1_addr_i(rs1_addr),
    .rs1_data_o(rs1_data),
    .rs2_addr_i(rs2_addr),
    .rs2_data_o(rs2_data),
    .rd_addr_i(rd_addr),
    .rd_data_i(rd_data),
    .rd_we_i(rd_we)
  );

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        q[$];
  logic        chk_stb = 1'b0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model [32];
  exp_t        mon_e;

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  task automatic expect_now(input string nm);
    exp_t e;
    e.name = nm;
    e.e1 = ref_rd(rs1_addr);
    e.e2 = ref_rd(rs2_addr);
    q.push_back(e);
    chk_stb = ~chk_stb;
  endtask

  // Pre-edge check sees old contents; post-edge check sees the write.
  task automatic drive(input logic we, input logic [4:0] rd,
                       input logic [31:0] d, input logic [4:0] a1,
                       input logic [4:0] a2, input string nm);
    @(negedge clk);
    rd_we = we;
    rd_addr = rd;
    rd_data = d;
    rs1_addr = a1;
    rs2_addr = a2;
    #1;
    expect_now({nm, "_pre"});
    @(posedge clk);
    if (we && rd != 5'd0 && !rst_i) model[rd] = d;
    #1;
    expect_now({nm, "_post"});
    rd_we = 1'b0;
  endtask

  always @(chk_stb) begin
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      checks += 2;
      if (rs1_data !== mon_e.e1) begin
        failures++;
        $display("FAIL %s rs1 addr=%0d got=%h exp=%h",
                 mon_e.name, rs1_addr, rs1_data, mon_e.e1);
      end
      if (rs2_data !== mon_e.e2) begin
        failures++;
        $display("FAIL %s rs2 addr=%0d got=%h exp=%h",
                 mon_e.name, rs2_addr, rs2_data, mon_e.e2);
      end
    end
  end

  task automatic reset_sweep(input string nm);
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      rs2_addr = 5'(31 - a);
      #1;
      expect_now(nm);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    #1 rst_i = 1'b1;
    #1;
    reset_sweep("init_rst");
    @(negedge clk);
    rst_i = 1'b0;

    drive(1'b1, 5'd5, 32'h0BADF00D, 5'd5, 5'd5, "seed5");
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd5, "wr5");
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "rd5");
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "x0");
    drive(1'b1, 5'd7, 32'hCAFE0007, 5'd7, 5'd0, "seed7");
    drive(1'b0, 5'd7, 32'h12345678, 5'd7, 5'd7, "we_low");
    drive(1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd31, "wr31");
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd31, "dual31");

    for (int i = 0; i < 64; i++) begin
      drive(1'($urandom_range(0, 1)), 5'(i), $urandom,
            5'(i - 1), 5'(i), $sformatf("sweep%0d", i));
    end

    // Reset with the clock stopped: contents must clear asynchronously.
    @(negedge clk);
    clk_en = 1'b0;
    #2;
    rst_i = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    reset_sweep("mid_rst");
    clk_en = 1'b1;
    drive(1'b1, 5'd3, 32'h33333333, 5'd3, 5'd3, "rst_held_wr");
    @(negedge clk);
    rst_i = 1'b0;
    drive(1'b1, 5'd3, 32'h0000C0DE, 5'd3, 5'd3, "first_wr");
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd5, "after_rst");

    for (int k = 0; k < 100 && q.size() != 0; k++) #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
